// File: rtl/fwd_if.sv
// Pipeline-side bundle of the forwarding scoreboard: issue, load return,
// operand read ports and register-file write-back.
interface fwd_if #(
  parameter int XLEN  = 32,
  parameter int NREAD = 2,
  parameter int RADDR = 5
);
  logic                   advance;
  logic                   flush;
  logic                   iss_we;
  logic                   iss_load;
  logic [RADDR-1:0]       iss_rd;
  logic [XLEN-1:0]        iss_data;
  logic                   mem_valid;
  logic [XLEN-1:0]        mem_rdata;
  logic [NREAD*RADDR-1:0] rs_addr;
  logic [NREAD*XLEN-1:0]  rf_data;
  logic [NREAD*XLEN-1:0]  fwd_data;
  logic                   hazard_stall;
  logic                   retire_block;
  logic                   wb_valid;
  logic [RADDR-1:0]       wb_rd;
  logic [XLEN-1:0]        wb_data;

  modport master (
    output advance, flush, iss_we, iss_load, iss_rd, iss_data,
    output mem_valid, mem_rdata, rs_addr, rf_data,
    input  fwd_data, hazard_stall, retire_block, wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  advance, flush, iss_we, iss_load, iss_rd, iss_data,
    input  mem_valid, mem_rdata, rs_addr, rf_data,
    output fwd_data, hazard_stall, retire_block, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// In-flight write tracker between EX and write-back: operand forwarding, load-use stall,
// variable-latency load fill. Optional FWD_STATS_EN adds saturating stat_fwd/stat_stall counters.
module fwd_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREAD = 2,
  parameter int DEPTH = 3,
  parameter int RADDR = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  fwd_if.slave        bus
`ifdef FWD_STATS_EN
  ,
  output logic [31:0] stat_fwd,
  output logic [31:0] stat_stall
`endif
);

  logic             slot_vld  [DEPTH];
  logic             slot_rdy  [DEPTH];
  logic             slot_ld   [DEPTH];
  logic [RADDR-1:0] slot_rd   [DEPTH];
  logic [XLEN-1:0]  slot_data [DEPTH];

  logic             nxt_vld  [DEPTH];
  logic             nxt_rdy  [DEPTH];
  logic             nxt_ld   [DEPTH];
  logic [RADDR-1:0] nxt_rd   [DEPTH];
  logic [XLEN-1:0]  nxt_data [DEPTH];

  logic             wb_vld_p1;
  logic [RADDR-1:0] wb_rd_p1;
  logic [XLEN-1:0]  wb_data_p1;

  logic             retire_blk;
  logic             shift;
  logic             capture;
  logic             fill_hit;
  int               fill_idx;
  logic [NREAD-1:0] port_stall;
  logic [NREAD-1:0] port_served;
  logic [NREAD*XLEN-1:0] fwd_vec;

  assign retire_blk = slot_vld[DEPTH-1] & ~slot_rdy[DEPTH-1];
  assign shift      = bus.advance & ~retire_blk;
  assign capture    = bus.iss_we & (|bus.iss_rd) & ~bus.flush;

  // Oldest pending load wins the returning data.
  always_comb begin : fill_sel
    fill_hit = 1'b0;
    fill_idx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld[i] && slot_ld[i] && !slot_rdy[i]) begin
        fill_hit = 1'b1;
        fill_idx = i;
      end
    end
  end

  always_comb begin : next_state
    for (int i = 0; i < DEPTH; i++) begin
      nxt_vld[i]  = slot_vld[i];
      nxt_rdy[i]  = slot_rdy[i];
      nxt_ld[i]   = slot_ld[i];
      nxt_rd[i]   = slot_rd[i];
      nxt_data[i] = slot_data[i];
    end
    if (shift) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        nxt_vld[i]  = slot_vld[i-1];
        nxt_rdy[i]  = slot_rdy[i-1];
        nxt_ld[i]   = slot_ld[i-1];
        nxt_rd[i]   = slot_rd[i-1];
        nxt_data[i] = slot_data[i-1];
      end
      nxt_vld[0]  = capture;
      nxt_rdy[0]  = capture & ~bus.iss_load;
      nxt_ld[0]   = capture & bus.iss_load;
      nxt_rd[0]   = capture ? bus.iss_rd : '0;
      nxt_data[0] = (capture && !bus.iss_load) ? bus.iss_data : '0;
    end
    // A shift can never move the filled entry out: it would have blocked retirement.
    if (bus.mem_valid && fill_hit) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == (shift ? fill_idx + 1 : fill_idx)) begin
          nxt_data[i] = bus.mem_rdata;
          nxt_rdy[i]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_vld[i]  <= 1'b0;
        slot_rdy[i]  <= 1'b0;
        slot_ld[i]   <= 1'b0;
        slot_rd[i]   <= '0;
        slot_data[i] <= '0;
      end
      wb_vld_p1  <= 1'b0;
      wb_rd_p1   <= '0;
      wb_data_p1 <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_vld[i]  <= nxt_vld[i];
        slot_rdy[i]  <= nxt_rdy[i];
        slot_ld[i]   <= nxt_ld[i];
        slot_rd[i]   <= nxt_rd[i];
        slot_data[i] <= nxt_data[i];
      end
      wb_vld_p1 <= shift & slot_vld[DEPTH-1];
      if (shift) begin
        wb_rd_p1   <= slot_rd[DEPTH-1];
        wb_data_p1 <= slot_data[DEPTH-1];
      end
    end
  end

  // Scan oldest to youngest so the youngest matching slot is the last to land.
  always_comb begin : forward
    logic             hit;
    logic             rdy;
    logic [XLEN-1:0]  dat;
    logic [RADDR-1:0] rs;
    port_stall  = '0;
    port_served = '0;
    fwd_vec     = '0;
    for (int p = 0; p < NREAD; p++) begin
      rs  = bus.rs_addr[p*RADDR +: RADDR];
      hit = 1'b0;
      rdy = 1'b0;
      dat = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (slot_vld[i] && slot_rd[i] == rs) begin
          hit = 1'b1;
          rdy = slot_rdy[i];
          dat = slot_data[i];
        end
      end
      if (rs == '0) begin
        fwd_vec[p*XLEN +: XLEN] = '0;
      end else if (hit && rdy) begin
        fwd_vec[p*XLEN +: XLEN] = dat;
        port_served[p]          = 1'b1;
      end else begin
        fwd_vec[p*XLEN +: XLEN] = bus.rf_data[p*XLEN +: XLEN];
        port_stall[p]           = hit;
      end
    end
  end

  assign bus.fwd_data     = fwd_vec;
  assign bus.hazard_stall = |port_stall;
  assign bus.retire_block = retire_blk;
  assign bus.wb_valid     = wb_vld_p1;
  assign bus.wb_rd        = wb_rd_p1;
  assign bus.wb_data      = wb_data_p1;

`ifdef FWD_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fwd   <= '0;
      stat_stall <= '0;
    end else begin
      if (|port_served) stat_fwd <= sat_inc(stat_fwd);
      if (|port_stall)  stat_stall <= sat_inc(stat_stall);
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard (DEPTH=3, NREAD=2): ALU chain, youngest-wins,
// load-use stall, late load at retire, x0/flush, and asynchronous reset.
module tb_fwd_scoreboard;
  localparam int XLEN  = 32;
  localparam int NREAD = 2;
  localparam int DEPTH = 3;
  localparam int RADDR = 5;
  localparam logic [XLEN-1:0] RF0 = 32'h1111_1111;
  localparam logic [XLEN-1:0] RF1 = 32'h2222_2222;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
`ifdef FWD_STATS_EN
  logic [31:0] stat_fwd;
  logic [31:0] stat_stall;
`endif

  fwd_if #(.XLEN(XLEN), .NREAD(NREAD), .RADDR(RADDR)) bus ();

  fwd_scoreboard #(.XLEN(XLEN), .NREAD(NREAD), .DEPTH(DEPTH), .RADDR(RADDR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FWD_STATS_EN
    ,
    .stat_fwd   (stat_fwd),
    .stat_stall (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_we    = 1'b0;
    bus.iss_load  = 1'b0;
    bus.flush     = 1'b0;
    bus.mem_valid = 1'b0;
  endtask

  task automatic issue(input logic ld, input logic [RADDR-1:0] rd, input logic [XLEN-1:0] d);
    bus.iss_we   = 1'b1;
    bus.iss_load = ld;
    bus.iss_rd   = rd;
    bus.iss_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle();
    bus.advance   = 1'b0;
    bus.iss_rd    = '0;
    bus.iss_data  = '0;
    bus.mem_rdata = '0;
    bus.rs_addr   = {5'd0, 5'd5};
    bus.rf_data   = {RF1, RF0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_rd", bus.wb_rd, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_stall", bus.hazard_stall, 0);
    chk("rst_retire", bus.retire_block, 0);
    chk("rst_fwd0_rf", bus.fwd_data[31:0], RF0);
`ifdef FWD_STATS_EN
    chk("rst_stat_fwd", stat_fwd, 0);
    chk("rst_stat_stall", stat_stall, 0);
`endif
    rst_n = 1'b1;

    // ALU chain
    issue(1'b0, 5'd5, 32'h11);
    bus.advance = 1'b1;
    tick();
    idle();
    bus.advance = 1'b0;
    bus.rs_addr = {5'd0, 5'd5};
    #1;
    chk("alu_fwd0", bus.fwd_data[31:0], 32'h11);
    chk("alu_stall", bus.hazard_stall, 0);
    bus.advance = 1'b1;
    tick();
    tick();
    chk("alu_wb_early", bus.wb_valid, 0);
    tick();
    chk("alu_wb_valid", bus.wb_valid, 1);
    chk("alu_wb_rd", bus.wb_rd, 5);
    chk("alu_wb_data", bus.wb_data, 32'h11);
    bus.advance = 1'b0;
    tick();
    chk("alu_wb_one_cycle", bus.wb_valid, 0);

    // Youngest wins
    issue(1'b0, 5'd3, 32'hA);
    bus.advance = 1'b1;
    tick();
    issue(1'b0, 5'd3, 32'hB);
    tick();
    idle();
    bus.advance = 1'b0;
    bus.rs_addr = {5'd4, 5'd3};
    #1;
    chk("young_fwd0", bus.fwd_data[31:0], 32'hB);
    chk("young_fwd1_rf", bus.fwd_data[63:32], RF1);
    chk("young_stall", bus.hazard_stall, 0);
    bus.advance = 1'b1;
    tick();
    tick();
    chk("young_wb_a", bus.wb_data, 32'hA);
    tick();
    chk("young_wb_b", bus.wb_data, 32'hB);
    chk("young_wb_rd", bus.wb_rd, 3);
    bus.advance = 1'b0;

    // Load-use stall
    issue(1'b1, 5'd7, 32'hFFFF);
    bus.advance = 1'b1;
    tick();
    idle();
    bus.advance = 1'b0;
    bus.rs_addr = {5'd0, 5'd7};
    #1;
    chk("ld_stall", bus.hazard_stall, 1);
    chk("ld_fwd0_rf", bus.fwd_data[31:0], RF0);
    chk("ld_retire", bus.retire_block, 0);
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 32'hDEAD;
    tick();
    bus.mem_valid = 1'b0;
    #1;
    chk("ld_stall_clear", bus.hazard_stall, 0);
    chk("ld_fwd0_data", bus.fwd_data[31:0], 32'hDEAD);
    bus.advance = 1'b1;
    repeat (3) tick();
    chk("ld_wb_valid", bus.wb_valid, 1);
    chk("ld_wb_rd", bus.wb_rd, 7);
    chk("ld_wb_data", bus.wb_data, 32'hDEAD);
    bus.advance = 1'b0;

    // Load return in the same cycle as a shift
    issue(1'b1, 5'd10, 32'h0);
    bus.advance = 1'b1;
    tick();
    idle();
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 32'h77;
    tick();
    bus.mem_valid = 1'b0;
    bus.advance   = 1'b0;
    bus.rs_addr   = {5'd0, 5'd10};
    #1;
    chk("fillshift_fwd0", bus.fwd_data[31:0], 32'h77);
    chk("fillshift_stall", bus.hazard_stall, 0);
    bus.advance = 1'b1;
    repeat (2) tick();
    chk("fillshift_wb_rd", bus.wb_rd, 10);
    chk("fillshift_wb_data", bus.wb_data, 32'h77);
    bus.advance = 1'b0;

    // Late load at retire
    issue(1'b1, 5'd8, 32'h0);
    bus.advance = 1'b1;
    tick();
    idle();
    repeat (2) tick();
    chk("late_retire", bus.retire_block, 1);
    tick();
    chk("late_blocked_wb", bus.wb_valid, 0);
    chk("late_retire_hold", bus.retire_block, 1);
    bus.rs_addr = {5'd0, 5'd8};
    #1;
    chk("late_stall", bus.hazard_stall, 1);
    bus.advance   = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 32'h42;
    tick();
    bus.mem_valid = 1'b0;
    chk("late_retire_clear", bus.retire_block, 0);
    chk("late_no_wb_yet", bus.wb_valid, 0);
    bus.advance = 1'b1;
    tick();
    chk("late_wb_valid", bus.wb_valid, 1);
    chk("late_wb_rd", bus.wb_rd, 8);
    chk("late_wb_data", bus.wb_data, 32'h42);
    bus.advance = 1'b0;

    // x0 and flush
    issue(1'b0, 5'd0, 32'h55);
    bus.advance = 1'b1;
    tick();
    idle();
    bus.advance = 1'b0;
    bus.rs_addr = {5'd0, 5'd0};
    #1;
    chk("x0_fwd0", bus.fwd_data[31:0], 0);
    chk("x0_fwd1", bus.fwd_data[63:32], 0);
    chk("x0_stall", bus.hazard_stall, 0);
    issue(1'b0, 5'd9, 32'h99);
    bus.flush   = 1'b1;
    bus.advance = 1'b1;
    tick();
    idle();
    bus.advance = 1'b0;
    bus.rs_addr = {5'd0, 5'd9};
    #1;
    chk("flush_fwd0_rf", bus.fwd_data[31:0], RF0);
    issue(1'b0, 5'd9, 32'h99);
    bus.advance = 1'b1;
    #1;
    chk("same_cycle_invisible", bus.fwd_data[31:0], RF0);
    tick();
    idle();
    bus.advance = 1'b0;
    #1;
    chk("captured_visible", bus.fwd_data[31:0], 32'h99);

    // Asynchronous reset with a pending load
    issue(1'b1, 5'd12, 32'h0);
    bus.advance = 1'b1;
    tick();
    idle();
    repeat (2) tick();
    chk("prerst_wb_data", bus.wb_data, 32'h99);
    chk("prerst_retire", bus.retire_block, 1);
    bus.advance = 1'b0;
    bus.rs_addr = {5'd0, 5'd12};
    #1;
    chk("prerst_stall", bus.hazard_stall, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_wb_valid", bus.wb_valid, 0);
    chk("arst_wb_rd", bus.wb_rd, 0);
    chk("arst_wb_data", bus.wb_data, 0);
    chk("arst_retire", bus.retire_block, 0);
    chk("arst_stall", bus.hazard_stall, 0);
    chk("arst_fwd0", bus.fwd_data[31:0], RF0);
`ifdef FWD_STATS_EN
    chk("arst_stat_fwd", stat_fwd, 0);
    chk("arst_stat_stall", stat_stall, 0);
`endif
    #1;
    rst_n = 1'b1;
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 32'h5A;
    tick();
    bus.mem_valid = 1'b0;
    chk("postrst_fwd0", bus.fwd_data[31:0], RF0);
    chk("postrst_stall", bus.hazard_stall, 0);
    chk("postrst_retire", bus.retire_block, 0);
    bus.advance = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      tick();
      chk("postrst_no_wb", bus.wb_valid, 0);
    end
    bus.advance = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the combinational store-data MEM->MEM forwarding logic.
- Tracks DEPTH in-flight register writes between EX and register-file write-back.
- Supplies forwarded operands to NREAD read ports and raises a stall when a needed load result has not yet returned.
- Drives the RF write-back port from its oldest slot. Supports variable-latency load data.

Parameters:
- XLEN, 32, datapath width.
- NREAD, 2, number of operand read ports.
- DEPTH, 3, in-flight write slots (slot 0 youngest, slot DEPTH-1 oldest); must be >= 1.
- RADDR, 5, register address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- advance  in  1  pipeline moves this cycle.
- flush  in  1  kill the issue being captured this cycle.
- iss_we  in  1  issuing instruction writes a register.
- iss_load  in  1  issuing instruction is a load.
- iss_rd  in  RADDR  destination register.
- iss_data  in  XLEN  EX result, ignored for loads.
- mem_valid  in  1  load data returns this cycle.
- mem_rdata  in  XLEN  returned load data.
- rs_addr  in  NREAD*RADDR  packed source register addresses.
- rf_data  in  NREAD*XLEN  packed register-file read data.
- fwd_data  out  NREAD*XLEN  resolved operands.
- hazard_stall  out  1  an operand depends on a pending load.
- retire_block  out  1  oldest slot is an unreturned load.
- wb_valid  out  1  write-back valid.
- wb_rd  out  RADDR  write-back register.
- wb_data  out  XLEN  write-back data.

Behaviour:
- Slot state (per slot): valid, rd, data, ready, load. Reset clears all of it; wb_* = 0, hazard_stall = 0, retire_block = 0.
- Capture rule: an issue is captured only when iss_we=1, iss_rd!=0 and flush=0. Otherwise slot 0 receives valid=0.
- Captured non-load: ready=1, data=iss_data.
- Captured load: ready=0, data=0.
- Shift condition: shift = advance & ~retire_block.
- On shift:
  - slot[i+1] <= slot[i].
  - slot 0 <= capture.
  - slot DEPTH-1 leaves and is written back.
- With shift=0, slots hold and the issue is dropped; upstream must not advance while retire_block=1.
- retire_block = slot[DEPTH-1].valid & ~slot[DEPTH-1].ready.
- wb_valid/wb_rd/wb_data are registered. They reflect the entry retiring on the previous shift edge and remain valid for exactly one cycle.
- Load return:
  - mem_valid fills the oldest valid, not-ready load slot: data <= mem_rdata, ready <= 1.
  - If a shift happens in the same cycle, the fill lands on that entry at its new position.
  - mem_valid with no pending load is ignored.
- Forwarding, per port p, combinational:
  - rs_addr[p]==0 -> fwd_data = 0.
  - Otherwise the youngest valid slot with rd == rs_addr[p] wins.
  - If the winner is ready, fwd_data = its data. If not ready, fwd_data = rf_data[p] and this port stalls.
  - No match -> rf_data[p].
- Older slots with the same rd never override a younger slot.
- hazard_stall = OR of per-port stalls. It does not gate the internal shift; the stage owner deasserts advance on stall.
- The entry captured this cycle is not visible to forwarding until the next cycle.
- Reset mid-operation discards all pending entries immediately, including outstanding loads.

Optional Feature:
- Macro FWD_STATS_EN.
- When defined, adds outputs stat_fwd (32) and stat_stall (32).
  - stat_fwd counts cycles in which at least one port is served from a slot.
  - stat_stall counts cycles with hazard_stall=1.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- ALU chain: issue rd=5, data=0x11, advance. Next cycle rs_addr[0]=5 -> fwd_data[0]=0x11. After DEPTH shifts -> wb_valid=1, wb_rd=5, wb_data=0x11 for one cycle.
- Youngest wins:
  - Issue rd=3/0xA, then rd=3/0xB, advancing each cycle.
  - Read rs=3 -> 0xB; rs=4 -> rf_data.
- Load-use stall:
  - Issue load rd=7. Read rs=7 -> hazard_stall=1.
  - mem_valid with 0xDEAD -> next cycle stall=0, fwd=0xDEAD.
- Late load at retire: load reaches slot DEPTH-1 unreturned -> retire_block=1, advance ignored, no write-back. mem_valid 0x42 -> write-back rd/0x42 after the next shift.
- x0 and flush:
  - rd=0 issue -> no slot valid, rs=0 reads 0.
  - flush with rd=9 -> rs=9 returns rf_data.
- Async reset with pending load -> all outputs 0 immediately; subsequent mem_valid ignored. With FWD_STATS_EN, counters read 0.
